// File: rtl/attn_pkg.sv
// Shared types and constants for the attention-core job controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package attn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CORE_RST,
        ST_RUN,
        ST_DRAIN
    } state_e;

    localparam int N_WORDS         = 32;
    localparam int KEY_BASE        = 0;
    localparam int QUERY_BASE      = 32;
    localparam int VALUE_BASE      = 64;
    localparam int TOTAL_WORDS     = 96;
    localparam int TIMEOUT_DEFAULT = 4095;

endpackage

// File: rtl/attn_word_serializer.sv
// Captures a wide result and emits it as N_WORDS words, word 0 first, with last on the final word.
// Latency: first word valid the cycle after load_i.
// Backpressure: holds data/last/valid while out_ready_i is low; one word per cycle when ready.
module attn_word_serializer #(
    parameter int WORD_W  = 16,
    parameter int N_WORDS = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load_i,
    input  logic [WORD_W*N_WORDS-1:0] data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [WORD_W-1:0]         out_data_o,
    output logic                      out_last_o,
    output logic                      done_o
);

    localparam int IDX_W = $clog2(N_WORDS);

    logic [WORD_W*N_WORDS-1:0] res_q;
    logic [IDX_W-1:0]          idx_q;
    logic                      vld_q;
    logic                      hs;

    assign hs          = vld_q & out_ready_i;
    assign out_valid_o = vld_q;
    assign out_data_o  = res_q[idx_q*WORD_W +: WORD_W];
    assign out_last_o  = vld_q && (idx_q == IDX_W'(N_WORDS - 1));
    assign done_o      = hs && out_last_o;

    // Load the result, then step through the words on each accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            idx_q <= '0;
            vld_q <= 1'b0;
        end else if (load_i) begin
            res_q <= data_i;
            idx_q <= '0;
            vld_q <= 1'b1;
        end else if (hs) begin
            if (out_last_o) begin
                vld_q <= 1'b0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/attn_job_ctrl.sv
// Job controller for the 8x8 attention core: pack 96 operand words, run the core, stream out 32 result words.
// Latency: core_en 2 cycles after the last input handshake; result word 0 valid 1 cycle after core_done.
// Backpressure: in_ready only in LOAD; result words held while out_ready is low.
module attn_job_ctrl
    import attn_pkg::*;
#(
    parameter int WORD_W  = 16,
    parameter int N_WORDS = attn_pkg::N_WORDS,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_W-1:0]         in_data,
    input  logic                      in_last,
    output logic [WORD_W*N_WORDS-1:0] core_key,
    output logic [WORD_W*N_WORDS-1:0] core_query,
    output logic [WORD_W*N_WORDS-1:0] core_value,
    output logic                      core_en,
    output logic                      core_rst_n,
    input  logic [WORD_W*N_WORDS-1:0] core_res,
    input  logic                      core_done,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_W-1:0]         out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      err
);

    state_e                    state_q;
    logic [6:0]                wcnt_q;
    logic [11:0]               tcnt_q;
    logic                      core_en_q;
    logic                      core_rst_n_q;
    logic [WORD_W*N_WORDS-1:0] core_key_q;
    logic [WORD_W*N_WORDS-1:0] core_query_q;
    logic [WORD_W*N_WORDS-1:0] core_value_q;

    logic       in_hs;
    logic       last_slot;
    logic       frame_err;
    logic       timeout_hit;
    logic       ser_load;
    logic       ser_done;
    logic [6:0] woff;

    assign in_hs       = (state_q == ST_LOAD) && in_valid;
    assign last_slot   = (wcnt_q == 7'(TOTAL_WORDS - 1));
    assign frame_err   = in_hs && (in_last != last_slot);
    assign timeout_hit = (state_q == ST_RUN) && !core_done && (tcnt_q == 12'(TIMEOUT));
    assign ser_load    = (state_q == ST_RUN) && core_done;

    // err is a same-cycle flag so it lines up with the offending word or the final RUN cycle.
    assign err        = frame_err || timeout_hit;
    assign in_ready   = (state_q == ST_LOAD);
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_LOAD);
    assign core_en    = core_en_q;
    assign core_rst_n = core_rst_n_q;
    assign core_key   = core_key_q;
    assign core_query = core_query_q;
    assign core_value = core_value_q;

    // Word slot within its operand region (regions are consecutive, 32 words each).
    always_comb begin
        woff = wcnt_q - 7'(KEY_BASE);
        if (wcnt_q >= 7'(VALUE_BASE)) begin
            woff = wcnt_q - 7'(VALUE_BASE);
        end else if (wcnt_q >= 7'(QUERY_BASE)) begin
            woff = wcnt_q - 7'(QUERY_BASE);
        end
    end

    // Job sequencing, operand packing, and the registered core controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wcnt_q       <= '0;
            tcnt_q       <= '0;
            core_en_q    <= 1'b0;
            core_rst_n_q <= 1'b0;
            core_key_q   <= '0;
            core_query_q <= '0;
            core_value_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: state_q <= ST_LOAD;
                ST_LOAD: begin
                    if (in_hs) begin
                        if (frame_err) begin
                            // Restart framing; earlier words stay until overwritten.
                            wcnt_q <= '0;
                        end else begin
                            if (wcnt_q >= 7'(VALUE_BASE)) begin
                                core_value_q[woff*WORD_W +: WORD_W] <= in_data;
                            end else if (wcnt_q >= 7'(QUERY_BASE)) begin
                                core_query_q[woff*WORD_W +: WORD_W] <= in_data;
                            end else begin
                                core_key_q[woff*WORD_W +: WORD_W] <= in_data;
                            end
                            if (last_slot) begin
                                wcnt_q  <= '0;
                                state_q <= ST_CORE_RST;
                            end else begin
                                wcnt_q <= wcnt_q + 1'b1;
                            end
                        end
                    end
                end
                ST_CORE_RST: begin
                    state_q      <= ST_RUN;
                    core_en_q    <= 1'b1;
                    core_rst_n_q <= 1'b1;
                    tcnt_q       <= '0;
                end
                ST_RUN: begin
                    if (core_done) begin
                        state_q      <= ST_DRAIN;
                        core_en_q    <= 1'b0;
                        core_rst_n_q <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q      <= ST_LOAD;
                        core_en_q    <= 1'b0;
                        core_rst_n_q <= 1'b0;
                        wcnt_q       <= '0;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (ser_done) begin
                        state_q <= ST_LOAD;
                        wcnt_q  <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    attn_word_serializer #(
        .WORD_W  (WORD_W),
        .N_WORDS (N_WORDS)
    ) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (ser_load),
        .data_i      (core_res),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .done_o      (ser_done)
    );

endmodule

// File: tb/tb_attn_job_ctrl.sv
// Bench for attn_job_ctrl: operand packing, core handshake, result streaming, framing error, timeout, reset.
// Latency: checks the 2-cycle load-to-enable and 1-cycle done-to-output relationships.
// Backpressure: exercises continuous and alternating out_ready.
module tb_attn_job_ctrl;

    localparam int TO = 20;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic [15:0]  in_data = '0;
    logic         in_ready;
    logic [511:0] core_key, core_query, core_value;
    logic [511:0] core_res = '0;
    logic         core_en, core_rst_n;
    logic         core_done = 1'b0;
    logic         out_valid, out_last, busy, err;
    logic         out_ready = 1'b0;
    logic [15:0]  out_data;

    int n_vec = 0;
    int n_bad = 0;
    logic [15:0]  exp_q[$];
    logic [511:0] exp_key = '0;
    logic [511:0] exp_query = '0;
    logic [511:0] exp_value = '0;

    always #5 clk = ~clk;

    attn_job_ctrl #(.WORD_W(16), .N_WORDS(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .core_key(core_key), .core_query(core_query), .core_value(core_value),
        .core_en(core_en), .core_rst_n(core_rst_n), .core_res(core_res), .core_done(core_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) cyc();
        n_vec++;
        if ({in_ready, core_en, core_rst_n, out_valid, out_last, busy, err} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b, want 0000000",
                     {in_ready, core_en, core_rst_n, out_valid, out_last, busy, err});
        end
        n_vec++;
        if ((core_key | core_query | core_value) !== 512'b0) begin
            n_bad++;
            $display("FAIL reset_buses: got nonzero operand bus, want 0");
        end
        n_vec++;
        if (out_data !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_out_data: got %h, want 0000", out_data);
        end
        rst_n = 1'b1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL in_ready_at_release: got %b, want 0", in_ready);
        end
        cyc();
        n_vec++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL in_ready_after_release: got ready=%b busy=%b, want ready=1 busy=0", in_ready, busy);
        end
    endtask

    // Drives one framed job; bad_at >= 0 raises in_last early on that word and stops there.
    task automatic load_job(input logic [15:0] kb, input logic [15:0] qb, input logic [15:0] vb,
                            input int bad_at);
        int last_k;
        last_k = (bad_at >= 0) ? bad_at : 95;
        for (int k = 0; k <= last_k; k++) begin
            logic [15:0] w;
            if (k < 32)      w = kb + 16'(k);
            else if (k < 64) w = qb + 16'(k - 32);
            else             w = vb + 16'(k - 64);
            if (bad_at < 0) begin
                if (k < 32)      exp_key[16*k +: 16] = w;
                else if (k < 64) exp_query[16*(k-32) +: 16] = w;
                else             exp_value[16*(k-64) +: 16] = w;
            end
            in_valid = 1'b1;
            in_data  = w;
            in_last  = (k == last_k);
            #1;
            n_vec++;
            if (in_ready !== 1'b1 || err !== (k == bad_at)) begin
                n_bad++;
                $display("FAIL load_word%0d: got ready=%b err=%b, want ready=1 err=%b",
                         k, in_ready, err, (k == bad_at));
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic core_start(input bit done_in_rst);
        n_vec++;
        if ({core_en, core_rst_n, busy, in_ready} !== 4'b0010) begin
            n_bad++;
            $display("FAIL core_rst_cycle: got en,rst_n,busy,ready=%b, want 0010",
                     {core_en, core_rst_n, busy, in_ready});
        end
        if (done_in_rst) begin
            core_done = 1'b1;
            core_res  = '1;
        end
        cyc();
        core_done = 1'b0;
        core_res  = '0;
        n_vec++;
        if (core_en !== 1'b1 || core_rst_n !== 1'b1) begin
            n_bad++;
            $display("FAIL core_en_rise: got en=%b rst_n=%b, want 1 1", core_en, core_rst_n);
        end
        n_vec++;
        if (core_key !== exp_key || core_query !== exp_query || core_value !== exp_value) begin
            n_bad++;
            $display("FAIL operand_buses: got key[31:0]=%h query[31:0]=%h value[31:0]=%h, want %h %h %h",
                     core_key[31:0], core_query[31:0], core_value[31:0],
                     exp_key[31:0], exp_query[31:0], exp_value[31:0]);
        end
    endtask

    task automatic run_core(input int delay, input logic [15:0] rb);
        repeat (delay) begin
            n_vec++;
            if (out_valid !== 1'b0 || core_en !== 1'b1) begin
                n_bad++;
                $display("FAIL run_wait: got valid=%b en=%b, want 0 1", out_valid, core_en);
            end
            cyc();
        end
        core_done = 1'b1;
        for (int i = 0; i < 32; i++) begin
            core_res[16*i +: 16] = rb + 16'(i);
            exp_q.push_back(rb + 16'(i));
        end
        cyc();
        core_done = 1'b0;
        core_res  = '0;
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== rb || core_en !== 1'b0 || core_rst_n !== 1'b0) begin
            n_bad++;
            $display("FAIL done_to_output: got valid=%b data=%h en=%b rst_n=%b, want 1 %h 0 0",
                     out_valid, out_data, core_en, core_rst_n, rb);
        end
    endtask

    task automatic drain(input bit toggle, input int stop_after, input bit junk_done, output int cycles);
        int          hs;
        bit          phase;
        bit          stalled;
        logic [15:0] held;
        logic        held_last;
        logic [15:0] exp;
        hs = 0; phase = 1'b1; stalled = 1'b0; cycles = 0; held = '0; held_last = 1'b0;
        while (hs < stop_after && cycles < 300) begin
            out_ready = toggle ? phase : 1'b1;
            core_done = junk_done && (hs == 5);
            core_res  = core_done ? '1 : '0;
            n_vec++;
            if (out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL drain_valid: got %b at word %0d, want 1", out_valid, hs);
            end
            if (stalled) begin
                n_vec++;
                if (out_data !== held || out_last !== held_last) begin
                    n_bad++;
                    $display("FAIL stall_hold: got %h/%b, want %h/%b", out_data, out_last, held, held_last);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                stalled = 1'b0;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL drain_extra: got word %h, want none", out_data);
                end else begin
                    exp = exp_q.pop_front();
                    if (out_data !== exp || out_last !== (hs == 31)) begin
                        n_bad++;
                        $display("FAIL drain_word%0d: got %h last=%b, want %h last=%b",
                                 hs, out_data, out_last, exp, (hs == 31));
                    end
                end
                hs++;
            end else if (out_valid === 1'b1) begin
                stalled   = 1'b1;
                held      = out_data;
                held_last = out_last;
            end
            phase = !phase;
            cycles++;
            cyc();
        end
        out_ready = 1'b0;
        core_done = 1'b0;
        core_res  = '0;
        n_vec++;
        if (hs != stop_after) begin
            n_bad++;
            $display("FAIL drain_count: got %0d handshakes, want %0d", hs, stop_after);
        end
    endtask

    task automatic check_back_in_load(input string tag);
        n_vec++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got ready=%b busy=%b valid=%b, want 1 0 0", tag, in_ready, busy, out_valid);
        end
    endtask

    task automatic test_basic();
        int c;
        load_job(16'h0001, 16'h0100, 16'h1000, -1);
        core_start(1'b0);
        n_vec++;
        if (core_key[15:0] !== 16'h0001 || core_query[511:496] !== 16'h011F || core_value[31:16] !== 16'h1001) begin
            n_bad++;
            $display("FAIL spot_words: got %h %h %h, want 0001 011f 1001",
                     core_key[15:0], core_query[511:496], core_value[31:16]);
        end
        run_core(4, 16'h0100);
        drain(1'b0, 32, 1'b0, c);
        n_vec++;
        if (c != 32) begin
            n_bad++;
            $display("FAIL drain_consecutive: got %0d cycles, want 32", c);
        end
        check_back_in_load("basic_back_to_load");
    endtask

    task automatic test_stall();
        int c;
        load_job(16'hA000, 16'hB000, 16'hC000, -1);
        core_start(1'b1);
        run_core(2, 16'h5A00);
        drain(1'b1, 32, 1'b1, c);
        n_vec++;
        if (c != 63) begin
            n_bad++;
            $display("FAIL drain_toggle_cycles: got %0d cycles, want 63", c);
        end
        check_back_in_load("stall_back_to_load");
    endtask

    task automatic test_framing();
        int c;
        load_job(16'h2000, 16'h2100, 16'h2200, 40);
        check_back_in_load("framing_stays_in_load");
        load_job(16'h3000, 16'h3100, 16'h3200, -1);
        core_start(1'b0);
        run_core(1, 16'h7700);
        drain(1'b0, 32, 1'b0, c);
        check_back_in_load("framing_recovered");
    endtask

    task automatic test_timeout();
        load_job(16'h4000, 16'h4100, 16'h4200, -1);
        core_start(1'b0);
        for (int i = 0; i <= TO; i++) begin
            n_vec++;
            if (err !== (i == TO) || core_en !== 1'b1) begin
                n_bad++;
                $display("FAIL timeout_cycle%0d: got err=%b en=%b, want err=%b en=1", i, err, core_en, (i == TO));
            end
            cyc();
        end
        n_vec++;
        if (core_en !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_abort: got en=%b ready=%b err=%b valid=%b, want 0 1 0 0",
                     core_en, in_ready, err, out_valid);
        end
    endtask

    task automatic test_reset_mid_drain();
        int c;
        load_job(16'h6000, 16'h6100, 16'h6200, -1);
        core_start(1'b0);
        run_core(3, 16'h0900);
        drain(1'b0, 10, 1'b0, c);
        n_vec++;
        if (out_data !== 16'h090A) begin
            n_bad++;
            $display("FAIL drain_word10_present: got %h, want 090a", out_data);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({in_ready, core_en, core_rst_n, out_valid, out_last, busy, err} !== 7'b0 || out_data !== 16'h0
            || (core_key | core_query | core_value) !== 512'b0) begin
            n_bad++;
            $display("FAIL async_reset: got ctrl=%b data=%h, want 0000000 0000",
                     {in_ready, core_en, core_rst_n, out_valid, out_last, busy, err}, out_data);
        end
        exp_q.delete();
        exp_key = '0; exp_query = '0; exp_value = '0;
        cyc();
        rst_n = 1'b1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_at_release2: got %b, want 0", in_ready);
        end
        cyc();
        check_back_in_load("ready_after_release2");
        load_job(16'h0E00, 16'h0E40, 16'h0E80, -1);
        core_start(1'b0);
        run_core(5, 16'hD000);
        drain(1'b0, 32, 1'b0, c);
        check_back_in_load("post_reset_job");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_framing();
        test_timeout();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
